// File: rtl/source_dose_sequencer.sv
// rtl/source_dose_sequencer.sv - peristaltic dose sequencer for the Source inlet valves
module source_dose_sequencer #(
   parameter int STROKE_W   = 8,
   parameter int PHASE_CYC  = 4,
   parameter int SETTLE_CYC = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic [STROKE_W-1:0] req_strokes,
   output logic                req_ready,
   input  logic                abort,
   output logic [2:0]          valve,
   output logic                pump_busy,
   output logic                dose_done,
   output logic                dose_aborted,
   output logic [STROKE_W-1:0] strokes_done
);

   localparam int PCW = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
   localparam int SCW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [PCW-1:0] P_LAST = PCW'(PHASE_CYC - 1);
   localparam logic [SCW-1:0] S_LAST = SCW'(SETTLE_CYC - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_PUMP   = 2'd1;
   localparam logic [1:0] S_SETTLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0]          r_state;
   logic [PCW-1:0]      r_pcnt;
   logic [2:0]          r_pidx;
   logic [SCW-1:0]      r_scnt;
   logic [STROKE_W-1:0] r_remaining;
   logic [STROKE_W-1:0] r_strokes_done;
   logic [2:0]          r_valve;
   logic                r_pump_busy;
   logic                r_dose_done;
   logic                r_dose_aborted;

   logic [1:0]          w_next_state;
   logic [PCW-1:0]      w_next_pcnt;
   logic [2:0]          w_next_pidx;
   logic [SCW-1:0]      w_next_scnt;
   logic                w_ready;
   logic                w_accept;
   logic                w_stroke_end;
   logic                w_busy_abort;

   // Bit = 1 closes the valve; one stroke walks the occluded pair down the tube.
   function automatic logic [2:0] phase_pattern(input logic [2:0] idx);
      case (idx)
         3'd0:    phase_pattern = 3'b101;
         3'd1:    phase_pattern = 3'b100;
         3'd2:    phase_pattern = 3'b110;
         3'd3:    phase_pattern = 3'b010;
         3'd4:    phase_pattern = 3'b011;
         3'd5:    phase_pattern = 3'b001;
         default: phase_pattern = 3'b111;
      endcase
   endfunction

   assign w_ready      = (r_state == S_IDLE) && !abort && !rst;
   assign w_accept     = req_valid && w_ready;
   assign w_busy_abort = abort && ((r_state == S_PUMP) || (r_state == S_SETTLE));
   assign w_stroke_end = (r_state == S_PUMP) && !abort && (r_pcnt == P_LAST) && (r_pidx == 3'd5);

   always_comb begin
      w_next_state = r_state;
      w_next_pcnt  = r_pcnt;
      w_next_pidx  = r_pidx;
      w_next_scnt  = r_scnt;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_next_pcnt  = '0;
               w_next_pidx  = 3'd0;
               w_next_scnt  = '0;
               w_next_state = (req_strokes == '0) ? S_SETTLE : S_PUMP;
            end
         end
         S_PUMP: begin
            if (abort) begin
               w_next_state = S_IDLE;
            end else if (r_pcnt == P_LAST) begin
               w_next_pcnt = '0;
               if (r_pidx == 3'd5) begin
                  w_next_pidx = 3'd0;
                  if (r_remaining == STROKE_W'(1)) begin
                     w_next_state = S_SETTLE;
                     w_next_scnt  = '0;
                  end
               end else begin
                  w_next_pidx = r_pidx + 3'd1;
               end
            end else begin
               w_next_pcnt = r_pcnt + PCW'(1);
            end
         end
         S_SETTLE: begin
            if (abort) begin
               w_next_state = S_IDLE;
            end else if (r_scnt == S_LAST) begin
               w_next_state = S_DONE;
            end else begin
               w_next_scnt = r_scnt + SCW'(1);
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // Outputs are registered from next-state so they line up with the state they describe.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= S_IDLE;
         r_pcnt         <= '0;
         r_pidx         <= 3'd0;
         r_scnt         <= '0;
         r_remaining    <= '0;
         r_strokes_done <= '0;
         r_valve        <= 3'b111;
         r_pump_busy    <= 1'b0;
         r_dose_done    <= 1'b0;
         r_dose_aborted <= 1'b0;
      end else begin
         r_state        <= w_next_state;
         r_pcnt         <= w_next_pcnt;
         r_pidx         <= w_next_pidx;
         r_scnt         <= w_next_scnt;
         r_valve        <= (w_next_state == S_PUMP) ? phase_pattern(w_next_pidx) : 3'b111;
         r_pump_busy    <= (w_next_state == S_PUMP) || (w_next_state == S_SETTLE);
         r_dose_done    <= (w_next_state == S_DONE);
         r_dose_aborted <= w_busy_abort;
         if (w_accept) begin
            r_remaining    <= req_strokes;
            r_strokes_done <= '0;
         end else if (w_stroke_end) begin
            r_remaining    <= r_remaining - STROKE_W'(1);
            r_strokes_done <= r_strokes_done + STROKE_W'(1);
         end
      end
   end

   assign req_ready    = w_ready;
   assign valve        = r_valve;
   assign pump_busy    = r_pump_busy;
   assign dose_done    = r_dose_done;
   assign dose_aborted = r_dose_aborted;
   assign strokes_done = r_strokes_done;

endmodule
